int_stack_sequencer: RTL

- Sequences multi-cycle control flow around the execute stage: hardware interrupt entry and RTI return.
- Freezes fetch and lets in-flight instructions drain.
- Injects stack micro-ops (push PC, push flags, pop flags, pop PC) into the ID/EX buffer in place of decoded instructions.
- Drives the PC load for the vector or the popped return address.
- Sits beside the decoder and drives the ID/EX injection mux and the PC-source mux.

---
 rtl/int_stack_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/int_stack_sequencer.sv
// Interrupt-entry / RTI-return sequencer: stalls fetch, drains the pipe, injects
// stack micro-ops into ID/EX and loads the PC with the vector or the popped return address.
module int_stack_sequencer #(
  parameter logic [31:0] VECTOR_ADDR  = 32'd0,
  parameter int          DRAIN_CYCLES = 3,
  parameter int          RET_LAT      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT_In,
  input  logic        RTI_Decoded,
  input  logic        Pipe_Busy,
  input  logic [31:0] Current_PC,
  input  logic [31:0] Popped_PC,
  output logic        Stall_Fetch,
  output logic        Inject_Valid,
  output logic [2:0]  Inject_Op,
  output logic [31:0] Saved_PC,
  output logic        PC_Load,
  output logic [31:0] PC_Target,
  output logic        Int_Ack,
  output logic        Busy
);

  localparam logic [3:0] IDLE       = 4'd0;
  localparam logic [3:0] INT_DRAIN  = 4'd1;
  localparam logic [3:0] PUSH_PC    = 4'd2;
  localparam logic [3:0] PUSH_FLAGS = 4'd3;
  localparam logic [3:0] VECTOR     = 4'd4;
  localparam logic [3:0] RTI_DRAIN  = 4'd5;
  localparam logic [3:0] POP_FLAGS  = 4'd6;
  localparam logic [3:0] POP_PC     = 4'd7;
  localparam logic [3:0] RET_WAIT   = 4'd8;
  localparam logic [3:0] RETURN     = 4'd9;

  localparam logic [2:0] OP_NONE      = 3'd0;
  localparam logic [2:0] OP_PUSH_PC   = 3'd1;
  localparam logic [2:0] OP_PUSH_FLGS = 3'd2;
  localparam logic [2:0] OP_POP_FLGS  = 3'd3;
  localparam logic [2:0] OP_POP_PC    = 3'd4;

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
  localparam logic [3:0] WAIT_LAST  = 4'(RET_LAT - 1);

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic [3:0] counter;
  logic       pending;
  logic       int_in_d;
  logic       int_rise;
  logic       enter_int;

  assign int_rise  = INT_In & ~int_in_d;
  assign enter_int = (state == IDLE) && (state_nxt == INT_DRAIN);

  // RTI wins over a pending interrupt; pending is only looked at in IDLE, so no nesting.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (RTI_Decoded)                 state_nxt = RTI_DRAIN;
        else if (pending && !Pipe_Busy)  state_nxt = INT_DRAIN;
      end
      INT_DRAIN:  if (counter == DRAIN_LAST) state_nxt = PUSH_PC;
      PUSH_PC:    state_nxt = PUSH_FLAGS;
      PUSH_FLAGS: state_nxt = VECTOR;
      VECTOR:     state_nxt = IDLE;
      RTI_DRAIN:  if (counter == DRAIN_LAST) state_nxt = POP_FLAGS;
      POP_FLAGS:  state_nxt = POP_PC;
      POP_PC:     state_nxt = RET_WAIT;
      RET_WAIT:   if (counter == WAIT_LAST) state_nxt = RETURN;
      RETURN:     state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= 1'b0;
      int_in_d <= 1'b0;
      counter  <= 4'd0;
      Saved_PC <= 32'd0;
    end else begin
      state    <= state_nxt;
      int_in_d <= INT_In;
      counter  <= (state_nxt != state) ? 4'd0 : counter + 4'd1;
      // A new edge in the same cycle as the clear is kept so it is serviced next.
      if (int_rise)       pending <= 1'b1;
      else if (enter_int) pending <= 1'b0;
      if (enter_int) Saved_PC <= Current_PC;
    end
  end

  always_comb begin
    Stall_Fetch  = 1'b0;
    Inject_Valid = 1'b0;
    Inject_Op    = OP_NONE;
    PC_Load      = 1'b0;
    PC_Target    = 32'd0;
    Int_Ack      = 1'b0;
    Busy         = (state != IDLE);
    case (state)
      INT_DRAIN, RTI_DRAIN, RET_WAIT: Stall_Fetch = 1'b1;
      PUSH_PC: begin
        Stall_Fetch  = 1'b1;
        Inject_Valid = 1'b1;
        Inject_Op    = OP_PUSH_PC;
      end
      PUSH_FLAGS: begin
        Stall_Fetch  = 1'b1;
        Inject_Valid = 1'b1;
        Inject_Op    = OP_PUSH_FLGS;
      end
      VECTOR: begin
        Stall_Fetch = 1'b1;
        PC_Load     = 1'b1;
        PC_Target   = VECTOR_ADDR;
        Int_Ack     = 1'b1;
      end
      POP_FLAGS: begin
        Stall_Fetch  = 1'b1;
        Inject_Valid = 1'b1;
        Inject_Op    = OP_POP_FLGS;
      end
      POP_PC: begin
        Stall_Fetch  = 1'b1;
        Inject_Valid = 1'b1;
        Inject_Op    = OP_POP_PC;
      end
      RETURN: begin
        Stall_Fetch = 1'b1;
        PC_Load     = 1'b1;
        PC_Target   = Popped_PC;
      end
      default: ;
    endcase
  end

endmodule
